registers_module_7x13: RTL and testbench



---
 rtl/registers_module_7x13.sv | 68 ++++++
 tb/tb_registers_module_7x13.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/registers_module_7x13.sv
// Seven-word storage bank for the alarm clock datapath: time and alarm words
// written from a shared data bus, all words continuously visible.
module registers_module_7x13 #(
  parameter int unsigned WIDTH = 13
) (
  output logic [WIDTH-1:0] Q_r0,
  output logic [WIDTH-1:0] Q_r1,
  output logic [WIDTH-1:0] Q_r2,
  output logic [WIDTH-1:0] Q_r3,
  output logic [WIDTH-1:0] Q_r4,
  output logic [WIDTH-1:0] Q_r5,
  output logic [WIDTH-1:0] Q_r6,
  input  logic [2:0]       STO,
  input  logic [WIDTH-1:0] D,
  input  logic             Clear,
  input  logic             Clock,
  input  logic             Enable
);

  localparam int unsigned NREGS = 7;

  logic [NREGS-1:0] wr_sel;
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] regs_q [NREGS];

  // One-hot store decode; STO=7 selects nothing, so that write is dropped.
  always_comb begin
    wr_sel = '0;
    if (Enable) begin
      unique case (STO)
        3'd0:    wr_sel = 7'b000_0001;
        3'd1:    wr_sel = 7'b000_0010;
        3'd2:    wr_sel = 7'b000_0100;
        3'd3:    wr_sel = 7'b000_1000;
        3'd4:    wr_sel = 7'b001_0000;
        3'd5:    wr_sel = 7'b010_0000;
        3'd6:    wr_sel = 7'b100_0000;
        default: wr_sel = '0;
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      regs_d[i] = wr_sel[i] ? D : regs_q[i];
    end
  end

  // Clear has priority over any write on the same edge.
  always_ff @(posedge Clock) begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (!Clear) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign Q_r0 = regs_q[0];
  assign Q_r1 = regs_q[1];
  assign Q_r2 = regs_q[2];
  assign Q_r3 = regs_q[3];
  assign Q_r4 = regs_q[4];
  assign Q_r5 = regs_q[5];
  assign Q_r6 = regs_q[6];

endmodule

// File: tb/tb_registers_module_7x13.sv
// Directed, table-driven bench for the seven-word register bank.
module tb_registers_module_7x13;

  logic        Clock;
  logic        Clear;
  logic        Enable;
  logic [2:0]  STO;
  logic [12:0] D;
  logic [12:0] Q_r0, Q_r1, Q_r2, Q_r3, Q_r4, Q_r5, Q_r6;
  logic [12:0] q [7];

  int checks;
  int failures;

  typedef struct {
    string       name;
    logic        clr;
    logic        en;
    logic [2:0]  sto;
    logic [12:0] d;
    logic [12:0] exp [7];
  } vec_t;

  vec_t vecs[$];

  registers_module_7x13 #(.WIDTH(13)) dut (
    .Q_r0   (Q_r0),
    .Q_r1   (Q_r1),
    .Q_r2   (Q_r2),
    .Q_r3   (Q_r3),
    .Q_r4   (Q_r4),
    .Q_r5   (Q_r5),
    .Q_r6   (Q_r6),
    .STO    (STO),
    .D      (D),
    .Clear  (Clear),
    .Clock  (Clock),
    .Enable (Enable)
  );

  assign q[0] = Q_r0;
  assign q[1] = Q_r1;
  assign q[2] = Q_r2;
  assign q[3] = Q_r3;
  assign q[4] = Q_r4;
  assign q[5] = Q_r5;
  assign q[6] = Q_r6;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic add(input string name, input logic clr, input logic en, input logic [2:0] sto,
                     input logic [12:0] d, input logic [12:0] e0, input logic [12:0] e1,
                     input logic [12:0] e2, input logic [12:0] e3, input logic [12:0] e4,
                     input logic [12:0] e5, input logic [12:0] e6);
    vec_t v;
    v.name = name; v.clr = clr; v.en = en; v.sto = sto; v.d = d;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    v.exp[4] = e4; v.exp[5] = e5; v.exp[6] = e6;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [12:0] exp);
    checks++;
    if (q[idx] !== exp) begin
      failures++;
      $display("FAIL %s Q_r%0d got=%h expected=%h", name, idx, q[idx], exp);
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs sampled the same way.
  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      Clear  = vecs[i].clr;
      Enable = vecs[i].en;
      STO    = vecs[i].sto;
      D      = vecs[i].d;
      @(posedge Clock);
      #1;
      for (int r = 0; r < 7; r++) check(vecs[i].name, r, vecs[i].exp[r]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Clear    = 1'b1;
    Enable   = 1'b0;
    STO      = 3'd0;
    D        = 13'd0;

    add("clear_reset",    0, 1, 3'd5, 13'h1ABC, 0, 0, 0, 0, 0, 0, 0);
    add("write_r0",       1, 1, 3'd0, 13'h01FF, 13'h01FF, 0, 0, 0, 0, 0, 0);
    // index 2: resumes after the falling-edge sequence
    add("write_r2",       1, 1, 3'd2, 13'h1983, 13'h01FF, 0, 13'h1983, 0, 0, 0, 0);
    add("rewrite_r2",     1, 1, 3'd2, 13'h1983, 13'h01FF, 0, 13'h1983, 0, 0, 0, 0);
    add("walk_r0",        1, 1, 3'd0, 13'd1, 1, 0, 13'h1983, 0, 0, 0, 0);
    add("walk_r1",        1, 1, 3'd1, 13'd2, 1, 2, 13'h1983, 0, 0, 0, 0);
    add("walk_r2",        1, 1, 3'd2, 13'd3, 1, 2, 3, 0, 0, 0, 0);
    add("walk_r3",        1, 1, 3'd3, 13'd4, 1, 2, 3, 4, 0, 0, 0);
    add("walk_r4",        1, 1, 3'd4, 13'd5, 1, 2, 3, 4, 5, 0, 0);
    add("walk_r5",        1, 1, 3'd5, 13'd6, 1, 2, 3, 4, 5, 6, 0);
    add("walk_r6",        1, 1, 3'd6, 13'd7, 1, 2, 3, 4, 5, 6, 7);
    add("sto7_dropped",   1, 1, 3'd7, 13'h1FFF, 1, 2, 3, 4, 5, 6, 7);
    add("enable_low",     1, 0, 3'd3, 13'd0, 1, 2, 3, 4, 5, 6, 7);
    add("clear_wins",     0, 1, 3'd3, 13'd3, 0, 0, 0, 0, 0, 0, 0);
    add("release_write",  1, 1, 3'd6, 13'h0AAA, 0, 0, 0, 0, 0, 0, 13'h0AAA);
    add("msb_r4",         1, 1, 3'd4, 13'h1000, 0, 0, 0, 0, 13'h1000, 0, 13'h0AAA);
    add("lsb_r1",         1, 1, 3'd1, 13'h0001, 0, 1, 0, 0, 13'h1000, 0, 13'h0AAA);

    @(posedge Clock);
    #1;
    run_range(0, 1);

    // Bus activity around a falling edge, with Enable dropped before the next rise.
    Enable = 1'b1;
    STO    = 3'd1;
    D      = 13'h19FF;
    @(negedge Clock);
    #1;
    check("fall_edge_r1", 1, 13'd0);
    STO = 3'd5;
    D   = 13'h0F0F;
    #1;
    check("stable_clk_r5", 5, 13'd0);
    Enable = 1'b0;
    @(posedge Clock);
    #1;
    check("no_write_r1", 1, 13'd0);
    check("no_write_r0", 0, 13'h01FF);

    run_range(2, vecs.size() - 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
